// File: rtl/ahb_lite_regbus_bridge.sv
// ahb_lite_regbus_bridge: AHB-Lite slave that maps one address window onto
// CHANNELS independent 8-register peripheral buses (channel index taken from
// HADDR[CH_SHIFT +: CH_IDX_W], register index from HADDR[4:2]).
// Writes complete with zero wait states; reads take 2+RD_WAIT cycles.
// Optional feature macro: AHB_REGBUS_ERR_EN -- when defined, invalid accesses
// (channel >= CHANNELS or HSIZE > word) get a two-cycle ERROR response;
// otherwise they complete OKAY without touching the register bus.
module ahb_lite_regbus_bridge #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CH_IDX_W = 2,
  parameter int unsigned CH_SHIFT = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RD_WAIT  = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic                       HREADY,
  input  logic [31:0]                HWDATA,
  output logic [31:0]                HRDATA,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [CHANNELS-1:0]        rb_sel,
  output logic [2:0]                 rb_addr,
  output logic [DATA_W-1:0]          rb_wdata,
  output logic                       rb_we,
  output logic                       rb_re,
  input  logic [CHANNELS*DATA_W-1:0] rb_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RWAIT,
    S_RDONE
`ifdef AHB_REGBUS_ERR_EN
    , S_ERR1,
    S_ERR2
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CH_IDX_W-1:0] ch_q, ch_d;
  logic [2:0]          addr_q, addr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                ok_q, ok_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rd_mux;
  logic [CH_IDX_W-1:0] ch_in;
  logic                accept;
  logic                bad_in;
  logic                take;
  logic                unused_bits;

  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign ch_in       = HADDR[CH_SHIFT +: CH_IDX_W];
  assign bad_in      = (32'(ch_in) >= CHANNELS) || (HSIZE > 3'd2);
  assign unused_bits = ^{HADDR, HTRANS[0], HWDATA};

  assign HRDATA   = 32'(rdata_q);
  assign rb_addr  = addr_q;
  assign rb_wdata = rb_we ? HWDATA[DATA_W-1:0] : '0;

  // State, latched address phase, wait counter and captured read data
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
    end
  end

  // Read-data mux for the latched channel
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch_q == CH_IDX_W'(k)) rd_mux = rb_rdata[k*DATA_W +: DATA_W];
    end
  end

  // One-hot channel select, only while a strobe is active
  always_comb begin
    rb_sel = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      rb_sel[k] = (rb_we | rb_re) & (ch_q == CH_IDX_W'(k));
    end
  end

  // Next-state, bus handshake and strobe generation
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ok_d      = ok_q;
    rdata_d   = rdata_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    rb_we     = 1'b0;
    rb_re     = 1'b0;
    take      = 1'b0;

    case (state_q)
      S_IDLE, S_RDONE: take = 1'b1;
      S_WR: begin
        rb_we = ok_q;
        take  = 1'b1;
      end
      S_RD: begin
        HREADYOUT = 1'b0;
        rb_re     = ok_q;
        // invalid reads (no-error build) skip the wait counter and return 0
        if (!ok_q) begin
          rdata_d = '0;
          state_d = S_RDONE;
        end else if (RD_WAIT == 0) begin
          rdata_d = rd_mux;
          state_d = S_RDONE;
        end else begin
          cnt_d   = 3'(RD_WAIT);
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = rd_mux;
          state_d = S_RDONE;
        end
      end
`ifdef AHB_REGBUS_ERR_EN
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP = 1'b1;
        take  = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      state_d = S_IDLE;
      if (accept) begin
        ch_d   = ch_in;
        addr_d = HADDR[4:2];
        ok_d   = !bad_in;
`ifdef AHB_REGBUS_ERR_EN
        if (bad_in) state_d = S_ERR1;
        else        state_d = HWRITE ? S_WR : S_RD;
`else
        state_d = HWRITE ? S_WR : S_RD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_regbus_bridge.sv
// tb_ahb_lite_regbus_bridge: randomized AHB-Lite traffic against a
// register-array reference model; a negedge monitor checks strobes and
// data-phase responses popped from expectation queues.
module tb_ahb_lite_regbus_bridge;

  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CH_IDX_W = 2;
  localparam int unsigned CH_SHIFT = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RD_WAIT  = 2;
`ifdef AHB_REGBUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                       HCLK   = 1'b0;
  logic                       HRESET = 1'b0;
  logic                       HSEL   = 1'b0;
  logic [31:0]                HADDR  = '0;
  logic [1:0]                 HTRANS = '0;
  logic                       HWRITE = 1'b0;
  logic [2:0]                 HSIZE  = '0;
  logic                       HREADY;
  logic [31:0]                HWDATA = '0;
  logic [31:0]                HRDATA;
  logic                       HREADYOUT;
  logic                       HRESP;
  logic [CHANNELS-1:0]        rb_sel;
  logic [2:0]                 rb_addr;
  logic [DATA_W-1:0]          rb_wdata;
  logic                       rb_we;
  logic                       rb_re;
  logic [CHANNELS*DATA_W-1:0] rb_rdata;
  logic                       hrdy_en = 1'b1;

  assign HREADY = HREADYOUT & hrdy_en;

  always #5 HCLK = ~HCLK;

  ahb_lite_regbus_bridge #(
    .CHANNELS(CHANNELS),
    .CH_IDX_W(CH_IDX_W),
    .CH_SHIFT(CH_SHIFT),
    .DATA_W  (DATA_W),
    .RD_WAIT (RD_WAIT)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HREADY   (HREADY),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .rb_sel   (rb_sel),
    .rb_addr  (rb_addr),
    .rb_wdata (rb_wdata),
    .rb_we    (rb_we),
    .rb_re    (rb_re),
    .rb_rdata (rb_rdata)
  );

  // Peripheral register blocks sitting on the register bus
  logic [DATA_W-1:0] periph [CHANNELS][8];
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int r = 0; r < 8; r++) periph[c][r] <= '0;
    end else if (rb_we) begin
      for (int c = 0; c < CHANNELS; c++)
        if (rb_sel[c]) periph[c][rb_addr] <= rb_wdata;
    end
  end
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) rb_rdata[c*DATA_W +: DATA_W] = periph[c][rb_addr];
  end

  // Reference model and scoreboard
  typedef struct { bit rd; bit err; int waits; logic [31:0] data; } resp_t;
  typedef struct { bit wr; logic [CHANNELS-1:0] sel; logic [2:0] addr; logic [DATA_W-1:0] data; } strobe_t;

  logic [DATA_W-1:0] ref_mem [CHANNELS][8];
  resp_t   rq[$];
  strobe_t sq[$];
  resp_t   cur;
  strobe_t exp_s;
  int      total = 0;
  int      bad = 0;
  bit      mon_en = 1'b0;
  bit      dp_active = 1'b0;
  int      waits = 0;
  bit      resp_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (HREADYOUT !== 1'b1) begin
      @(posedge HCLK); #1;
      guard++;
      if (guard > 40) begin
        total++; bad++;
        $display("FAIL ready_timeout: HREADYOUT=%b want 1", HREADYOUT);
        finish_run();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge HCLK); #1; end
  endtask

  task automatic issue(input bit wr, input int unsigned ch, input int unsigned rg,
                       input logic [2:0] sz, input logic [31:0] wd, input bit rnd_hi);
    resp_t   r;
    strobe_t s;
    bit      valid;
    logic [31:0] a;
    wait_ready();
    valid  = (ch < CHANNELS) && (sz <= 3'd2);
    r.rd   = !wr;
    r.err  = ERR_EN && !valid;
    r.data = '0;
    if (r.err)   r.waits = 1;
    else if (wr) r.waits = 0;
    else         r.waits = valid ? 1 + RD_WAIT : 1;
    if (!wr && valid) r.data = 32'(ref_mem[ch][rg]);
    rq.push_back(r);
    if (valid) begin
      s.wr = wr;
      s.sel = '0;
      s.sel[ch] = 1'b1;
      s.addr = rg[2:0];
      s.data = wd[DATA_W-1:0];
      sq.push_back(s);
      if (wr) ref_mem[ch][rg] = wd[DATA_W-1:0];
    end
    a = rnd_hi ? $urandom() : 32'h0;
    a[CH_SHIFT +: CH_IDX_W] = ch[CH_IDX_W-1:0];
    a[4:2] = rg[2:0];
    HSEL   = 1'b1;
    HTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = sz;
    @(posedge HCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = $urandom();
    HWDATA = wd;
  endtask

  // Address phases that must not be accepted
  task automatic noise(input int unsigned kind);
    wait_ready();
    HADDR    = $urandom();
    HADDR[6] = 1'b0;
    HWRITE   = $urandom_range(0, 1);
    HSIZE    = 3'd0;
    case (kind)
      0: begin HSEL = 1'b1; HTRANS = 2'b10; hrdy_en = 1'b0; end
      1: begin HSEL = 1'b1; HTRANS = 2'b01; end
      2: begin HSEL = 1'b0; HTRANS = 2'b10; end
      default: begin HSEL = 1'b1; HTRANS = 2'b00; end
    endcase
    @(posedge HCLK); #1;
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    hrdy_en = 1'b1;
  endtask

  // Monitor: strobes and data-phase completions against the queues
  always @(negedge HCLK) begin
    if (HRESET || !mon_en) begin
      dp_active = 1'b0;
    end else begin
      check("we_re_exclusive", 32'(rb_we & rb_re), 32'd0);
      if (rb_we || rb_re) begin
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: we=%b re=%b sel=%b want no strobe", rb_we, rb_re, rb_sel);
        end else begin
          exp_s = sq.pop_front();
          check("strobe_kind", 32'(rb_we), 32'(exp_s.wr));
          check("strobe_sel", 32'(rb_sel), 32'(exp_s.sel));
          check("strobe_addr", 32'(rb_addr), 32'(exp_s.addr));
          if (exp_s.wr) check("strobe_wdata", 32'(rb_wdata), 32'(exp_s.data));
          check("strobe_cycle", dp_active ? 32'(waits) : 32'd99, 32'd0);
        end
      end else begin
        check("sel_idle", 32'(rb_sel), 32'd0);
      end
      if (dp_active) begin
        if (!HREADYOUT) begin
          waits++;
          if (HRESP !== cur.err) resp_bad = 1'b1;
        end else begin
          check("wait_cycles", 32'(waits), 32'(cur.waits));
          check("hresp", 32'(HRESP), 32'(cur.err));
          check("hresp_during_wait", 32'(resp_bad), 32'd0);
          if (cur.rd && !cur.err) check("hrdata", HRDATA, cur.data);
          dp_active = 1'b0;
        end
      end else begin
        check("ready_idle", 32'(HREADYOUT), 32'd1);
      end
      if (HSEL && HTRANS[1] && HREADY) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_accept: HADDR=%0h want no transfer", HADDR);
        end else begin
          cur = rq.pop_front();
          dp_active = 1'b1;
          waits = 0;
          resp_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CHANNELS; c++)
      for (int r = 0; r < 8; r++) ref_mem[c][r] = '0;
    #1 HRESET = 1'b1;
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_we", 32'(rb_we), 32'd0);
    check("rst_re", 32'(rb_re), 32'd0);
    check("rst_sel", 32'(rb_sel), 32'd0);
    check("rst_addr", 32'(rb_addr), 32'd0);
    check("rst_wdata", 32'(rb_wdata), 32'd0);
    @(negedge HCLK); @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Reset in the middle of a read wait
    issue(1'b1, 0, 1, 3'd0, 32'h5A, 1'b0);
    issue(1'b0, 0, 1, 3'd0, 32'h0, 1'b0);
    wait_ready();
    check("hrdata_before_reset", HRDATA, 32'h5A);
    issue(1'b0, 0, 1, 3'd0, 32'h0, 1'b0);
    @(posedge HCLK); #1;
    check("in_rwait_ready", 32'(HREADYOUT), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    check("midrst_ready", 32'(HREADYOUT), 32'd1);
    check("midrst_re", 32'(rb_re), 32'd0);
    check("midrst_hrdata", HRDATA, 32'd0);
    check("midrst_hresp", 32'(HRESP), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    check("postrst_ready", 32'(HREADYOUT), 32'd1);
    for (int c = 0; c < CHANNELS; c++)
      for (int r = 0; r < 8; r++) ref_mem[c][r] = '0;
    rq.delete();
    sq.delete();
    mon_en = 1'b1;

    // Directed cases
    issue(1'b1, 1, 3, 3'd0, 32'h000000A5, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) issue(1'b1, 0, i, 3'd2, $urandom(), 1'b1);
    idle(1);
    issue(1'b1, 0, 5, 3'd0, 32'h3C, 1'b0);
    idle(1);
    issue(1'b0, 0, 5, 3'd2, 32'h0, 1'b0);
    issue(1'b1, 3, 0, 3'd0, $urandom(), 1'b1);
    issue(1'b0, 3, 1, 3'd0, 32'h0, 1'b1);
    issue(1'b1, 0, 0, 3'd3, $urandom(), 1'b1);
    issue(1'b0, 1, 2, 3'd4, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) noise(k);
    issue(1'b1, 1, 6, 3'd1, $urandom(), 1'b1);
    issue(1'b0, 1, 6, 3'd1, 32'h0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned ch;
      logic [2:0]  sz;
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), ch, $urandom_range(0, 7), sz, $urandom(), 1'b1);
      if ($urandom_range(0, 9) == 0) noise($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end

    idle(12);
    check("resp_queue_drained", 32'(rq.size()), 32'd0);
    check("strobe_queue_drained", 32'(sq.size()), 32'd0);
    check("no_open_data_phase", 32'(dp_active), 32'd0);
    finish_run();
  end

endmodule
